// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: stall/flush
// control of PC, IF/ID and ID/EX plus multiply/divide occupancy tracking.
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_UsesRt,
    input  logic        ID_Jump,
    input  logic        ID_MdStart,
    input  logic        ID_MdOp,
    input  logic        ID_MdRead,
    input  logic        EXE_ReadMen,
    input  logic [4:0]  EXE_Rw,
    input  logic        EXE_BrTaken,
    output logic        PC_WR,
    output logic        IF_ID_WR,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_WR,
    output logic        ID_EX_FLUSH,
    output logic        MD_Busy,
    output logic        MD_Done,
    output logic [31:0] StallCnt
);

    typedef enum logic {IDLE, BUSY} md_state_e;

    localparam logic [5:0] MULT_CNT = 6'(MULT_LAT - 1);
    localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT - 1);

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic md_busy;
    logic load_hz;
    logic md_hz;
    logic stall;
    logic start_acc;

    // Busy is forced low while reset is held so no hazard is raised from a stale FSM.
    always_comb begin
        md_busy   = (state_q == BUSY) & ~rst;
        load_hz   = EXE_ReadMen & (EXE_Rw != 5'd0) &
                    ((EXE_Rw == ID_rs) | (ID_UsesRt & (EXE_Rw == ID_rt)));
        md_hz     = md_busy & (ID_MdRead | ID_MdStart);
        stall     = (load_hz | md_hz) & ~EXE_BrTaken;
        start_acc = ID_MdStart & ~stall & ~EXE_BrTaken;
    end

    always_comb begin
        PC_WR       = 1'b1;
        IF_ID_WR    = 1'b1;
        IF_ID_FLUSH = 1'b0;
        ID_EX_WR    = 1'b1;
        ID_EX_FLUSH = 1'b0;
        if (rst || EXE_BrTaken) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end else if (stall) begin
            PC_WR       = 1'b0;
            IF_ID_WR    = 1'b0;
            ID_EX_FLUSH = 1'b1;
        end else if (ID_Jump) begin
            IF_ID_FLUSH = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = BUSY;
                    cnt_d   = ID_MdOp ? DIV_CNT : MULT_CNT;
                end
            end
            BUSY: begin
                if (cnt_q == 6'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign MD_Busy  = md_busy;
    assign MD_Done  = md_busy & (cnt_q == 6'd0);
    assign StallCnt = stall_cnt_q;

endmodule
